// File: rtl/obuf_drain_ctrl.sv
// Output-buffer fill/drain controller: writes VPU result columns into the
// output buffer, then streams them back out through a 2-entry skid FIFO to
// the AXI master, one column per cycle when the master never stalls.
module obuf_drain_ctrl #(
    parameter int DATA_WIDTH           = 32,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [ADDR_WIDTH:0]     cfg_num_cols,
    input  logic                    vpu_wr_valid,
    output logic                    obuf_wr_en,
    output logic [ADDR_WIDTH-1:0]   obuf_wr_addr,
    output logic                    obuf_rd_en,
    output logic [ADDR_WIDTH-1:0]   obuf_rd_addr,
    input  logic [DATA_WIDTH-1:0]   obuf_rd_data [SYSTOLIC_ARRAY_WIDTH],
    output logic [DATA_WIDTH-1:0]   m_data [SYSTOLIC_ARRAY_WIDTH],
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err_wr
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       wr_idx_q, wr_idx_d;
    logic [CW-1:0]       rd_idx_q, rd_idx_d;
    logic [CW-1:0]       pop_idx_q, pop_idx_d;
    logic                inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2][SYSTOLIC_ARRAY_WIDTH];
    logic [DATA_WIDTH-1:0] fifo_d [2][SYSTOLIC_ARRAY_WIDTH];
    logic                fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic                fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                err_q, err_d;

    logic                wr_fire;
    logic                rd_fire;
    logic                pop;
    logic                last_col;
    logic [2:0]          occupancy;

    // Next-state logic: config latch, write/read index tracking and FIFO bookkeeping
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        count_d       = count_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        pop_idx_d     = pop_idx_q;
        fifo_d        = fifo_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        err_d         = err_q;

        wr_fire   = (state_q == FILL) && vpu_wr_valid;
        pop       = (state_q == DRAIN) && (fifo_cnt_q != 2'd0) && m_ready;
        last_col  = (pop_idx_q == (count_q - CW'(1)));
        occupancy = {2'b00, inflight_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
        rd_fire   = (state_q == DRAIN) && (rd_idx_q < count_q) && (occupancy < 3'd2);

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    base_d    = cfg_base_addr;
                    count_d   = cfg_num_cols;
                    wr_idx_d  = '0;
                    rd_idx_d  = '0;
                    pop_idx_d = '0;
                    err_d     = 1'b0;
                    state_d   = (cfg_num_cols == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (wr_fire) begin
                    wr_idx_d = wr_idx_q + CW'(1);
                    if ((wr_idx_q + CW'(1)) == count_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_fire) begin
                    rd_idx_d = rd_idx_q + CW'(1);
                end
                if (pop) begin
                    pop_idx_d = pop_idx_q + CW'(1);
                    if (last_col) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = rd_fire;
        if (inflight_q) begin
            fifo_d[fifo_wr_ptr_q] = obuf_rd_data;
            fifo_wr_ptr_d         = ~fifo_wr_ptr_q;
        end
        if (pop) begin
            fifo_rd_ptr_d = ~fifo_rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

        if (vpu_wr_valid && (state_q != FILL)) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            count_q       <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            pop_idx_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_q        <= '{default: '{default: '0}};
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            pop_idx_q     <= pop_idx_d;
            inflight_q    <= inflight_d;
            fifo_q        <= fifo_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            err_q         <= err_d;
        end
    end

    // Output decode; everything is forced quiet while reset is held
    always_comb begin
        obuf_wr_en   = wr_fire;
        obuf_wr_addr = base_q + wr_idx_q[ADDR_WIDTH-1:0];
        obuf_rd_en   = rd_fire;
        obuf_rd_addr = base_q + rd_idx_q[ADDR_WIDTH-1:0];
        m_data       = fifo_q[fifo_rd_ptr_q];
        m_valid      = (state_q == DRAIN) && (fifo_cnt_q != 2'd0);
        m_last       = (state_q == DRAIN) && (fifo_cnt_q != 2'd0) && last_col;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        err_wr       = err_q;
        if (rst) begin
            obuf_wr_en   = 1'b0;
            obuf_wr_addr = '0;
            obuf_rd_en   = 1'b0;
            obuf_rd_addr = '0;
            for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++) begin
                m_data[i] = '0;
            end
            m_valid      = 1'b0;
            m_last       = 1'b0;
            busy         = 1'b0;
            done         = 1'b0;
            err_wr       = 1'b0;
        end
    end

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Self-checking bench for obuf_drain_ctrl: a buffer model serves the DUT's
// addresses, and a transaction-level reference model predicts every output.
module tb_obuf_drain_ctrl;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int AW   = 10;
    localparam int CNTW = AW + 1;
    localparam int CW   = DW * W;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW:0]   cfg_num_cols;
    logic          vpu_wr_valid;
    logic          obuf_wr_en;
    logic [AW-1:0] obuf_wr_addr;
    logic          obuf_rd_en;
    logic [AW-1:0] obuf_rd_addr;
    logic [DW-1:0] rd_data_arr [W];
    logic [DW-1:0] m_data_arr [W];
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err_wr;

    logic [CW-1:0] vpu_col;
    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] rd_q;
    logic [CW-1:0] m_flat;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    bit            active, exp_done, exp_err, rd_prev, prev_stalled;
    int            base, count, wr_cnt, rd_cnt, beat_cnt;
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] prev_exp;
    int            drain_start, first_valid, first_beat, last_beat, done_cnt;

    obuf_drain_ctrl #(
        .DATA_WIDTH(DW),
        .SYSTOLIC_ARRAY_WIDTH(W),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_cols(cfg_num_cols),
        .vpu_wr_valid(vpu_wr_valid),
        .obuf_wr_en(obuf_wr_en),
        .obuf_wr_addr(obuf_wr_addr),
        .obuf_rd_en(obuf_rd_en),
        .obuf_rd_addr(obuf_rd_addr),
        .obuf_rd_data(rd_data_arr),
        .m_data(m_data_arr),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .busy(busy),
        .done(done),
        .err_wr(err_wr)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-write buffer with one-cycle read latency
    always @(posedge clk) begin
        if (obuf_wr_en) mem[obuf_wr_addr] <= vpu_col;
        if (obuf_rd_en) rd_q <= mem[obuf_rd_addr];
    end

    // Unpacked/packed column conversion for the buffer port and the master port
    always_comb begin
        for (int i = 0; i < W; i++) begin
            rd_data_arr[i]       = rd_q[i*DW +: DW];
            m_flat[i*DW +: DW]   = m_data_arr[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        active = 0; exp_done = 0; exp_err = 0; rd_prev = 0; prev_stalled = 0;
        base = 0; count = 0; wr_cnt = 0; rd_cnt = 0; beat_cnt = 0;
        exp_q.delete();
    endtask

    task automatic applyStimulus(input int wr_pct, input int rdy_pct);
        rst          = 1'b0;
        cfg_start    = 1'b0;
        vpu_wr_valid = active && (wr_cnt < count) && ($urandom_range(99) < wr_pct);
        vpu_col      = {$urandom, $urandom, $urandom, $urandom};
        m_ready      = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: compare outputs mid-cycle, then advance the reference model
    task automatic cycle();
        bit filling, draining, exp_mvalid, pop, exp_rden, exp_last, new_done;
        int returned;
        @(negedge clk);
        filling    = active && (wr_cnt < count);
        draining   = active && (wr_cnt == count);
        returned   = rd_cnt - int'(rd_prev);
        exp_mvalid = draining && (beat_cnt < returned);
        pop        = exp_mvalid && m_ready;
        exp_rden   = draining && (rd_cnt < count) && ((rd_cnt - beat_cnt - int'(pop)) < 2);
        exp_last   = exp_mvalid && (beat_cnt == count - 1);
        if (rst) begin
            checkOutput("rst_wr_en",   CW'(obuf_wr_en),   '0);
            checkOutput("rst_rd_en",   CW'(obuf_rd_en),   '0);
            checkOutput("rst_wr_addr", CW'(obuf_wr_addr), '0);
            checkOutput("rst_rd_addr", CW'(obuf_rd_addr), '0);
            checkOutput("rst_m_valid", CW'(m_valid),      '0);
            checkOutput("rst_m_last",  CW'(m_last),       '0);
            checkOutput("rst_busy",    CW'(busy),         '0);
            checkOutput("rst_done",    CW'(done),         '0);
            checkOutput("rst_err",     CW'(err_wr),       '0);
        end else begin
            checkOutput("wr_en", CW'(obuf_wr_en), CW'(filling && vpu_wr_valid));
            if (obuf_wr_en)
                checkOutput("wr_addr", CW'(obuf_wr_addr), CW'((base + wr_cnt) % DEPTH));
            checkOutput("rd_en", CW'(obuf_rd_en), CW'(exp_rden));
            if (obuf_rd_en)
                checkOutput("rd_addr", CW'(obuf_rd_addr), CW'((base + rd_cnt) % DEPTH));
            checkOutput("m_valid", CW'(m_valid), CW'(exp_mvalid));
            checkOutput("m_last", CW'(m_last), CW'(exp_last));
            if (exp_mvalid && (beat_cnt < exp_q.size()))
                checkOutput("m_data", m_flat, exp_q[beat_cnt]);
            if (prev_stalled) begin
                checkOutput("stall_valid_held", CW'(m_valid), CW'(1));
                checkOutput("stall_data_held", m_flat, prev_exp);
            end
            checkOutput("busy", CW'(busy), CW'(active || exp_done));
            checkOutput("done", CW'(done), CW'(exp_done));
            checkOutput("err_wr", CW'(err_wr), CW'(exp_err));
        end
        if (done) done_cnt++;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        if (rst) begin
            modelReset();
        end else begin
            new_done = 0;
            if (cfg_start && !active && !exp_done) begin
                base     = int'(cfg_base_addr);
                count    = int'(cfg_num_cols);
                exp_err  = 0;
                wr_cnt   = 0;
                rd_cnt   = 0;
                beat_cnt = 0;
                exp_q.delete();
                if (count == 0) new_done = 1;
                else active = 1;
            end
            if (vpu_wr_valid && !filling) exp_err = 1;
            if (filling && vpu_wr_valid) begin
                exp_q.push_back(vpu_col);
                wr_cnt++;
                if (wr_cnt == count) drain_start = cyc + 1;
            end
            rd_prev = exp_rden;
            if (exp_rden) rd_cnt++;
            prev_stalled = exp_mvalid && !m_ready;
            if (exp_mvalid && (beat_cnt < exp_q.size())) prev_exp = exp_q[beat_cnt];
            if (pop) begin
                beat_cnt++;
                if (beat_cnt == count) begin
                    active   = 0;
                    new_done = 1;
                end
            end
            exp_done = new_done;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Launch one tile and run it to completion, with optional mid-drain disturbances
    task automatic runTile(input int b, input int n, input int wr_pct, input int rdy_pct,
                           input bit inject, input int rst_beat);
        int guard;
        bit injected, did_rst;
        guard = 0; injected = 0; did_rst = 0;
        done_cnt = 0; first_valid = -1; drain_start = -1; first_beat = -1; last_beat = -1;
        applyStimulus(wr_pct, rdy_pct);
        cfg_start     = 1'b1;
        cfg_base_addr = AW'(b);
        cfg_num_cols  = CNTW'(n);
        cycle();
        while ((active || exp_done) && guard < 3000) begin
            applyStimulus(wr_pct, rdy_pct);
            if (inject && !injected && active && wr_cnt == count && beat_cnt == 1) begin
                vpu_wr_valid  = 1'b1;
                cfg_start     = 1'b1;
                cfg_base_addr = AW'(7);
                cfg_num_cols  = CNTW'(2);
                injected      = 1;
            end
            if (rst_beat >= 0 && !did_rst && active && beat_cnt == rst_beat) begin
                rst     = 1'b1;
                did_rst = 1;
            end
            cycle();
            guard++;
        end
        checkOutput("tile_finished", CW'(active || exp_done), '0);
        checkOutput("done_pulses", CW'(done_cnt), CW'(did_rst ? 0 : 1));
        if (!did_rst && n > 0) begin
            checkOutput("first_valid_latency", CW'(first_valid - drain_start), CW'(2));
            if (rdy_pct == 100)
                checkOutput("throughput", CW'(last_beat - first_beat), CW'(n - 1));
        end
        checkOutput("err_after_tile", CW'(err_wr), CW'(inject));
    endtask

    initial begin
        modelReset();
        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_cols = '0;
        vpu_wr_valid = 1'b0; vpu_col = '0; m_ready = 1'b0;
        drain_start = -1; first_valid = -1; first_beat = -1; last_beat = -1; done_cnt = 0;
        prev_exp = '0;
        #1;
        cycle();
        cycle();
        applyStimulus(0, 100);
        cycle();
        checkOutput("post_reset_wr_addr", CW'(obuf_wr_addr), '0);
        checkOutput("post_reset_rd_addr", CW'(obuf_rd_addr), '0);
        checkOutput("post_reset_busy", CW'(busy), '0);

        $display("[TB] basic tile base=0 count=4");
        runTile(0, 4, 100, 100, 0, -1);

        $display("[TB] wrapping tile base=1022 count=4");
        runTile(1022, 4, 60, 100, 0, -1);

        $display("[TB] 16 columns with 50%% backpressure");
        runTile(int'($urandom_range(DEPTH - 1)), 16, 70, 50, 0, -1);

        $display("[TB] empty tile");
        runTile(500, 0, 100, 100, 0, -1);

        $display("[TB] stray VPU write while idle");
        applyStimulus(0, 100);
        vpu_wr_valid = 1'b1;
        cycle();
        applyStimulus(0, 100);
        cycle();
        checkOutput("idle_write_err", CW'(err_wr), CW'(1));

        $display("[TB] stray write and cfg_start during drain");
        runTile(5, 4, 100, 60, 1, -1);

        $display("[TB] reset after 2 of 8 beats, then a fresh tile");
        runTile(100, 8, 100, 100, 0, 2);
        applyStimulus(0, 100);
        cycle();
        checkOutput("post_drain_reset_busy", CW'(busy), '0);
        runTile(1020, 3, 100, 100, 0, -1);

        $display("[TB] random tiles");
        for (int t = 0; t < 4; t++) begin
            runTile(int'($urandom_range(DEPTH - 1)), int'($urandom_range(1, 20)),
                    int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), 0, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
